// File: rtl/spi_slave.sv
// spi_slave: SPI responder with a CPU-side 8-bit register port.
// SCK, SS_n and MOSI are oversampled in the i_clk domain. All four CPOL/CPHA
// modes are supported, with single-byte RX/TX buffers, overrun and an RX irq.

module spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_addr,
   input  logic       i_cs,
   input  logic       i_we,
   input  logic [7:0] i_dat,
   output logic [7:0] o_dat,
   input  logic       i_sck,
   input  logic       i_ss_n,
   input  logic       i_mosi,
   output logic       o_miso,
   output logic       o_miso_oe,
   output logic       o_irq
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t state, state_nx;

   // synchronizers, retimed copies and a post-reset settle tracker
   logic [SYNC_STAGES-1:0] sck_ff, ss_n_ff, mosi_ff;
   logic                   sck_d, sck_d2, ss_n_d, mosi_d;
   logic [SYNC_STAGES:0]   settle;
   logic                   ss_armed;

   // control / status and datapath state
   logic       cpol, cpha, ovr, tx_full, rx_full, pend_load, rbit;
   logic [7:0] tx_buf, rx_buf, sh;
   logic [2:0] cnt;

   // decoded strobes
   logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic go_active, go_idle, do_sample, do_shift, byte_done, tx_take;
   logic wr_ctl, wr_data, rd_ctl, rd_data, ss_active;
   logic [7:0] tx_next;

   assign ss_active = ~ss_n_d;

   // Bus decode; control writes are ignored while the master holds SS.
   assign wr_ctl  = i_cs &  i_we & ~i_addr & ~ss_active;
   assign wr_data = i_cs &  i_we &  i_addr;
   assign rd_ctl  = i_cs & ~i_we & ~i_addr;
   assign rd_data = i_cs & ~i_we &  i_addr;

   // SCK edge classification from the retimed copies.
   assign sck_rise    =  sck_d & ~sck_d2;
   assign sck_fall    = ~sck_d &  sck_d2;
   assign lead_edge   = cpol ? sck_fall : sck_rise;
   assign trail_edge  = cpol ? sck_rise : sck_fall;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge  : trail_edge;

   assign byte_done = do_sample & (cnt == 3'd7);
   assign tx_next   = tx_full ? tx_buf : 8'hFF;
   assign tx_take   = (go_active & ~cpha) | (do_shift & pend_load);

   assign o_dat     = i_addr ? rx_buf
                             : {ss_active, rx_full, tx_full, ovr, 2'b00, cpha, cpol};
   assign o_miso    = sh[7];
   assign o_miso_oe = ss_active;
   assign o_irq     = rx_full;

   // Pin synchronizers plus one retiming stage; edges compare the retimed pair.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         // SCK flops rest at cpol's reset level, SS_n at inactive.
         sck_ff  <= '0;
         ss_n_ff <= '1;
         mosi_ff <= '1;
         sck_d   <= 1'b0;
         sck_d2  <= 1'b0;
         ss_n_d  <= 1'b1;
         mosi_d  <= 1'b1;
         settle  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop here samples pre-edge values.
         sck_ff  <= {sck_ff[SYNC_STAGES-2:0], i_sck};
         ss_n_ff <= {ss_n_ff[SYNC_STAGES-2:0], i_ss_n};
         mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], i_mosi};
         sck_d   <= sck_ff[SYNC_STAGES-1];
         sck_d2  <= sck_d;
         ss_n_d  <= ss_n_ff[SYNC_STAGES-1];
         mosi_d  <= mosi_ff[SYNC_STAGES-1];
         settle  <= {settle[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nx;
   end

   // Next state and per-cycle event strobes.
   always_comb begin
      // NOTE: every output gets a default first, so this block never infers a latch.
      state_nx  = state;
      go_active = 1'b0;
      go_idle   = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
      case (state)
         IDLE: begin
            // Armed only after SS was seen inactive, so a reset mid-transfer
            // waits for a genuine SS falling edge.
            if (ss_armed && ss_active) begin
               state_nx  = ACTIVE;
               go_active = 1'b1;
            end
         end
         ACTIVE: begin
            if (!ss_active) begin
               state_nx = IDLE;
               go_idle  = 1'b1;
            end else begin
               do_sample = sample_edge;
               do_shift  = shift_edge;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Registers, buffers, shift register and flags.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         cpol      <= 1'b0;
         cpha      <= 1'b0;
         ovr       <= 1'b0;
         tx_full   <= 1'b0;
         rx_full   <= 1'b0;
         pend_load <= 1'b0;
         rbit      <= 1'b0;
         ss_armed  <= 1'b0;
         tx_buf    <= 8'h00;
         rx_buf    <= 8'h00;
         sh        <= 8'hFF;
         cnt       <= 3'd0;
      end else begin
         if (&settle && !ss_active) ss_armed <= 1'b1;

         if (wr_ctl) begin
            cpol <= i_dat[0];
            cpha <= i_dat[1];
         end

         // A reload consumes the old buffer; a same-cycle write refills it.
         if (tx_take) tx_full <= 1'b0;
         if (wr_data) begin
            tx_buf  <= i_dat;
            tx_full <= 1'b1;
         end

         if (go_active && !cpha)  sh <= tx_next;
         else if (do_shift)       sh <= pend_load ? tx_next : {sh[6:0], rbit};

         if (go_active)                   pend_load <= cpha;
         else if (go_idle)                pend_load <= 1'b0;
         else if (byte_done)              pend_load <= 1'b1;
         else if (do_shift && pend_load)  pend_load <= 1'b0;

         if (go_active || go_idle) cnt <= 3'd0;
         else if (do_sample)       cnt <= cnt + 3'd1;

         if (do_sample) rbit <= mosi_d;

         // Clears come first so a same-cycle set wins.
         if (rd_data) rx_full <= 1'b0;
         if (rd_ctl)  ovr     <= 1'b0;
         if (byte_done) begin
            rx_buf  <= {sh[6:0], mosi_d};
            rx_full <= 1'b1;
            if (rx_full && !rd_data) ovr <= 1'b1;
         end
      end
   end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the same 8-bit register bus as the SPI master: an external master drives SCK/SS/MOSI, this block returns MISO and exchanges one byte per 8 SCK cycles with the CPU. All SPI pins are oversampled in the single `i_clk` domain, so no second clock domain exists. The block supports all four CPOL/CPHA modes and provides single-byte RX/TX buffers, overrun detection and an RX interrupt.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `i_sck`, `i_ss_n` and `i_mosi` (minimum 2).
- `i_clk` in 1: system clock.
- `i_reset_n` in 1: synchronous, active-low reset.
- `i_addr` in 1: 0 = ctl/status, 1 = data.
- `i_cs` in 1: bus select.
- `i_we` in 1: write strobe (with `i_cs`).
- `i_dat` in 8: write data.
- `o_dat` out 8: combinational read data for `i_addr`.
- `i_sck` in 1: SPI clock from the master (asynchronous).
- `i_ss_n` in 1: slave select from the master, active low (asynchronous).
- `i_mosi` in 1: master-out data (asynchronous).
- `o_miso` out 1: `sh[7]`.
- `o_miso_oe` out 1: 1 while synchronized SS is active.
- `o_irq` out 1: equals `rx_full`.

## Operation
- Register 0 bit map:
  - bit0 `cpol` (rw).
  - bit1 `cpha` (rw).
  - bit4 `ovr` (ro, cleared by a read of reg 0).
  - bit5 `tx_full` (ro).
  - bit6 `rx_full` (ro).
  - bit7 `ss_active` (ro).
  - Other bits read 0.
- Writes to reg 0 while `ss_active`=1 are discarded.
- Register 1:
  - Write sets `tx_buf` = `i_dat` and `tx_full`=1. A write while already full overwrites the buffer.
  - Read returns `rx_buf`. A read (`i_cs & ~i_we & i_addr`) clears `rx_full`.
- Edge detection:
  - Synchronized SCK is compared with its previous value.
  - Leading edge is rising when cpol=0, falling when cpol=1. Trailing edge is the opposite.
  - Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other edge.
- Next TX byte = `tx_buf` if `tx_full`, else 0xFF. Taking it clears `tx_full`.
- State is IDLE / ACTIVE, following synchronized SS.
- IDLE→ACTIVE (SS falls):
  - `cnt`=0.
  - cpha=0: `sh` ← next TX byte.
  - cpha=1: `pend_load`=1.
- Sample edge in ACTIVE:
  - `rbit` ← MOSI, `cnt`++.
  - On the 8th sample: `rx_buf` ← {`sh[6:0]`, MOSI}, `rx_full`=1, `cnt`=0, `pend_load`=1.
  - If `rx_full` was already 1 and no same-cycle reg-1 read occurs: `ovr`=1 and `rx_buf` is overwritten.
- Shift edge in ACTIVE:
  - If `pend_load`: `sh` ← next TX byte, `pend_load`=0.
  - Else: `sh` ← {`sh[6:0]`, `rbit`}.
- ACTIVE→IDLE (SS rises, including mid-byte):
  - Partial byte is discarded.
  - `cnt`=0, `pend_load`=0.
  - `rx_buf`, `rx_full` and `tx_buf` are untouched.
- Simultaneous events:
  - Byte completion together with a reg-1 read: `rx_full` stays 1, `ovr` unchanged, new byte stored.
  - TX reload together with a reg-1 write: reload takes the old `tx_buf` value. The write then leaves `tx_full`=1 with the new data.
  - `ovr` set together with a reg-0 read: `ovr` ends at 1.
- Reset values:
  - `cpol`=`cpha`=0, `rx_buf`=`tx_buf`=0x00, `sh`=0xFF.
  - All flags 0, state IDLE, sync flops at the idle level (SCK=cpol, SS_n=1).
  - Outputs: `o_miso`=1, `o_miso_oe`=0, `o_irq`=0, `o_dat`=0x00 for addr 0.
- Reset mid-transfer aborts the transfer. The block resumes only after the next SS falling edge.

## Timing
- Pin-to-event latency: a pin change is acted on at the `SYNC_STAGES`+1-th `i_clk` rising edge after the first edge that samples it.
- `o_miso`, `rx_full` and `o_irq` change on that same edge.
- Master constraints, each in `i_clk` periods:
  - SCK high ≥ `SYNC_STAGES`+3.
  - SCK low ≥ `SYNC_STAGES`+3.
  - SS_n fall to first SCK edge ≥ `SYNC_STAGES`+3.
  - Last SCK edge to SS_n rise ≥ `SYNC_STAGES`+3.
- Register read data is combinational. Register writes take effect at the clock edge of the strobe.
- `rx_full` clears at the edge of the read strobe.

## Test plan
- Mode 0: write 0xA5 to reg 1, master sends 0x3C. Required: MISO bits 1,0,1,0,0,1,0,1; `o_irq`=1; reg 1 reads 0x3C; then `rx_full`=0 and `tx_full`=0.
- Mode 3 (ctl=0x03): load only 0x81, master sends 0x12 then 0x34 under one SS. Required: MISO carries 0x81 then 0xFF; the first 0x12 is flagged as overrun on byte 2; reg 1 reads 0x34; reg 0 reads 0xD3, then 0x83 on the following read.
- Mode 1 and mode 2 each carry 0x5A/0xC3 both directions intact.
- SS rises after 5 bits, then a full byte 0x99 follows. Required: `rx_full` stays 0 through the abort; reg 1 reads 0x99 afterwards.
- Write 0x02 to reg 0 while SS is active: cpha stays 0. Reg-1 read on the byte-completion cycle: `rx_full`=1 and `ovr`=0.
- Assert `i_reset_n`=0 after 4 bits: all reset values return. The next SS transfer of 0x7E is received correctly.
